// File: rtl/osd_pkg.sv
// Shared types and helpers for the OSD candidate pipeline:
// state encoding, default K, candidate vector type, pair count.
package osd_pkg;

    localparam int K_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN1,
        ST_GEN2,
        ST_FIN
    } osd_state_e;

    typedef logic [K_DEFAULT-1:0] osd_cand_t;

    function automatic int n_pairs(input int k);
        return (k * (k - 1)) / 2;
    endfunction

endpackage

// File: rtl/osd_pair_walker.sv
// Flip-position walker: i in 1-bit mode (j tracks i), then the
// lexicographic (i,j), i<j walk in 2-bit mode.
// Ports: init1/init2 load (0,0)/(0,1); step advances; mode2 picks
// the walk; pos_i/pos_j current pair; last1/last2 flag final pair.
module osd_pair_walker #(
    parameter int K  = 8,
    parameter int IW = $clog2(K) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init1,
    input  logic          init2,
    input  logic          step,
    input  logic          mode2,
    output logic [IW-1:0] pos_i,
    output logic [IW-1:0] pos_j,
    output logic          last1,
    output logic          last2
);

    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] LAST   = IW'(K - 1);
    localparam logic [IW-1:0] PENULT = IW'((K > 1) ? K - 2 : 0);

    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (init1) begin
            i_d = '0;
            j_d = '0;
        end else if (init2) begin
            i_d = '0;
            j_d = ONE;
        end else if (step) begin
            if (!mode2) begin
                i_d = i_q + ONE;
                j_d = j_q + ONE;
            end else if (j_q == LAST) begin
                // row finished: next row starts just right of new i
                i_d = i_q + ONE;
                j_d = i_q + ONE + ONE;
            end else begin
                j_d = j_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign pos_i = i_q;
    assign pos_j = j_q;
    assign last1 = (i_q == LAST);
    assign last2 = (i_q == PENULT) && (j_q == LAST);

endmodule

// File: rtl/osd_flip_pattern_gen.sv
// OSD flip-pattern source: latches base_vec on start, emits all
// order-1 then order-2 flips of it, then a one-cycle done pulse.
// Ports: start/abort/enable control, base_vec in; candidate_1bit,
// valid_1bit, candidate_2bit, valid_2bit, done_2bit, flip_i,
// flip_j, busy out (all registered).
module osd_flip_pattern_gen
    import osd_pkg::*;
#(
    parameter int K  = K_DEFAULT,
    parameter int IW = $clog2(K) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          enable,
    input  logic [K-1:0]  base_vec,
    output logic [K-1:0]  candidate_1bit,
    output logic          valid_1bit,
    output logic [K-1:0]  candidate_2bit,
    output logic          valid_2bit,
    output logic          done_2bit,
    output logic [IW-1:0] flip_i,
    output logic [IW-1:0] flip_j,
    output logic          busy
);

    localparam int           N2   = n_pairs(K);
    localparam logic [K-1:0] BIT0 = K'(1);

    osd_state_e    state_q, state_d;
    logic [K-1:0]  base_q, base_d;
    logic [K-1:0]  cand1_q, cand1_d;
    logic [K-1:0]  cand2_q, cand2_d;
    logic          v1_q, v1_d;
    logic          v2_q, v2_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] fi_q, fi_d;
    logic [IW-1:0] fj_q, fj_d;

    logic          w_init1, w_init2, w_step;
    logic          w_last1, w_last2;
    logic [IW-1:0] w_i, w_j;
    logic [K-1:0]  mask_i, mask_j;

    osd_pair_walker #(
        .K  (K),
        .IW (IW)
    ) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .init1 (w_init1),
        .init2 (w_init2),
        .step  (w_step),
        .mode2 (state_q == ST_GEN2),
        .pos_i (w_i),
        .pos_j (w_j),
        .last1 (w_last1),
        .last2 (w_last2)
    );

    assign mask_i = BIT0 << w_i;
    assign mask_j = BIT0 << w_j;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cand1_d = cand1_q;
        cand2_d = cand2_q;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        fi_d    = fi_q;
        fj_d    = fj_q;
        w_init1 = 1'b0;
        w_init2 = 1'b0;
        w_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GEN1;
                    base_d  = base_vec;
                    busy_d  = 1'b1;
                    w_init1 = 1'b1;
                end
            end
            ST_GEN1: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (enable) begin
                    cand1_d = base_q ^ mask_i;
                    v1_d    = 1'b1;
                    fi_d    = w_i;
                    fj_d    = w_i;
                    if (!w_last1) begin
                        w_step = 1'b1;
                    end else if (N2 == 0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_GEN2;
                        w_init2 = 1'b1;
                    end
                end
            end
            ST_GEN2: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (enable) begin
                    cand2_d = base_q ^ mask_i ^ mask_j;
                    v2_d    = 1'b1;
                    fi_d    = w_i;
                    fj_d    = w_j;
                    if (w_last2) begin
                        state_d = ST_FIN;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                // FIN spans the done cycle too, so a start seen
                // alongside done is still ignored.
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cand1_q <= '0;
            cand2_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fi_q    <= '0;
            fj_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cand1_q <= cand1_d;
            cand2_q <= cand2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fi_q    <= fi_d;
            fj_q    <= fj_d;
        end
    end

    assign candidate_1bit = cand1_q;
    assign valid_1bit     = v1_q;
    assign candidate_2bit = cand2_q;
    assign valid_2bit     = v2_q;
    assign done_2bit      = done_q;
    assign flip_i         = fi_q;
    assign flip_j         = fj_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_osd_flip_pattern_gen.sv
// Self-checking bench for osd_flip_pattern_gen (K=8 and K=4).
// Scoreboard of expected beats plus a table of full-pass cases.
module tb_osd_flip_pattern_gen;

    localparam int N2 = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, enable;
    logic [7:0] base_vec;
    logic [7:0] c1, c2;
    logic       v1, v2, done, busy;
    logic [3:0] fi, fj;

    logic       start4, abort4, enable4;
    logic [3:0] base4;
    logic [3:0] c1_4, c2_4;
    logic       v1_4, v2_4, done4, busy4;
    logic [2:0] fi4, fj4;

    osd_flip_pattern_gen #(.K(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .enable(enable), .base_vec(base_vec),
        .candidate_1bit(c1), .valid_1bit(v1),
        .candidate_2bit(c2), .valid_2bit(v2),
        .done_2bit(done), .flip_i(fi), .flip_j(fj), .busy(busy)
    );

    osd_flip_pattern_gen #(.K(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .enable(enable4), .base_vec(base4),
        .candidate_1bit(c1_4), .valid_1bit(v1_4),
        .candidate_2bit(c2_4), .valid_2bit(v2_4),
        .done_2bit(done4), .flip_i(fi4), .flip_j(fj4), .busy(busy4)
    );

    typedef struct packed {
        logic       two;
        logic [7:0] cand;
        logic [3:0] fi;
        logic [3:0] fj;
    } beat_t;

    typedef struct {
        logic [7:0] base;
        bit         stall;
        bit         poke;
        bit         hold;
        logic [7:0] first1;
        logic [7:0] first2;
        logic [7:0] last2;
    } vec_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;

    int         beats, n_done, first_v_cyc, last_v_cyc, done_cyc;
    bit         seen1, seen2;
    logic [7:0] first1, first2, last_c;
    logic [3:0] last_i, last_j;
    beat_t      got, exp_b;

    logic [3:0] got4[16];
    int         n4 = 0;
    int         n_done4 = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input logic [7:0] b, input int n2max);
        int cnt;
        logic [7:0] one;
        one = 8'd1;
        for (int i = 0; i < 8; i++)
            sb.push_back('{1'b0, b ^ (one << i), 4'(i), 4'(i)});
        cnt = 0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (cnt < n2max) begin
                    sb.push_back('{1'b1, b ^ (one << i) ^ (one << j),
                                   4'(i), 4'(j)});
                    cnt++;
                end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v1 || v2) begin
                check("valid_excl", {31'd0, v1 & v2}, 32'd0);
                got = '{v2, v2 ? c2 : c1, fi, fj};
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got %0h expected none", got);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", 32'(got), 32'(exp_b));
                end
                if (beats == 0) first_v_cyc = cyc;
                beats++;
                last_v_cyc = cyc;
                if (v1 && !seen1) begin first1 = c1; seen1 = 1; end
                if (v2 && !seen2) begin first2 = c2; seen2 = 1; end
                last_c = v2 ? c2 : c1;
                last_i = fi;
                last_j = fj;
            end
            if (done) begin
                check("done_no_valid", {31'd0, v1 | v2}, 32'd0);
                check("sb_empty_at_done", sb.size(), 32'd0);
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (v1_4 || v2_4) begin
                if (n4 < 16) got4[n4] = v2_4 ? c2_4 : c1_4;
                n4++;
            end
            if (done4) n_done4++;
        end
    end

    task automatic clear_mon();
        beats = 0; n_done = 0; first_v_cyc = 0; last_v_cyc = 0;
        done_cyc = 0; seen1 = 0; seen2 = 0;
    endtask

    task automatic run_pass(input vec_t v);
        int t_start;
        int k;
        clear_mon();
        push_pass(v.base, N2);
        base_vec = v.base;
        start = 1;
        t_start = cyc;
        tick();
        start = 0;
        base_vec = ~v.base;
        k = 0;
        while (n_done == 0 && k < 400) begin
            if (v.stall) enable = (k % 2 == 0);
            start = (v.poke && k == 3) || (v.hold && done);
            tick();
            k++;
        end
        start = 0;
        enable = 1;
        check("pass_done", n_done, 32'd1);
        check("beats", beats, 32'd36);
        check("first1", first1, v.first1);
        check("first2", first2, v.first2);
        check("last2", last_c, v.last2);
        check("last_ij", {last_i, last_j}, {4'd6, 4'd7});
        check("done_after_valid", {31'd0, done_cyc > last_v_cyc}, 32'd1);
        if (!v.stall) begin
            check("first_lat", first_v_cyc - t_start, 32'd2);
            check("done_lat", done_cyc - t_start, 32'd38);
        end
        check("busy_after_done", {31'd0, busy}, 32'd0);
        tick();
        check("busy_idle2", {31'd0, busy}, 32'd0);
        check("single_done", n_done, 32'd1);
    endtask

    vec_t tbl[4];

    initial begin
        logic [3:0] b4;
        logic [3:0] exp4[10];
        logic [3:0] one4;
        int k;
        int n2;

        tbl[0] = '{8'h00, 0, 0, 0, 8'h01, 8'h03, 8'hC0};
        tbl[1] = '{8'hFF, 0, 1, 0, 8'hFE, 8'hFC, 8'h3F};
        tbl[2] = '{8'h00, 1, 0, 1, 8'h01, 8'h03, 8'hC0};
        tbl[3] = '{8'hA5, 0, 0, 1, 8'hA4, 8'hA6, 8'h65};

        rst_n = 0; start = 0; abort = 0; enable = 1; base_vec = 0;
        start4 = 0; abort4 = 0; enable4 = 1; base4 = 0;
        clear_mon();
        repeat (2) tick();
        check("reset_outs", {4'd0, c1, c2, v1, v2, done, busy, fi, fj},
              32'd0);
        rst_n = 1;
        tick();

        for (int t = 0; t < 4; t++) run_pass(tbl[t]);

        // abort on the 5th 2-bit beat
        clear_mon();
        push_pass(8'h3C, 5);
        base_vec = 8'h3C;
        start = 1;
        tick();
        start = 0;
        k = 0;
        n2 = 0;
        while (k < 100) begin
            tick();
            k++;
            if (v2) begin
                n2++;
                if (n2 == 5) break;
            end
        end
        check("abort_reach", n2, 32'd5);
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, v1 | v2}, 32'd0);
        repeat (50) tick();
        check("abort_no_done", n_done, 32'd0);
        check("abort_sb", sb.size(), 32'd0);
        run_pass(tbl[0]);

        // async reset mid-GEN1
        clear_mon();
        push_pass(8'h55, N2);
        base_vec = 8'h55;
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("async_rst", {4'd0, c1, c2, v1, v2, done, busy, fi, fj},
              32'd0);
        start = 1;
        repeat (2) tick();
        check("rst_hold", {4'd0, c1, c2, v1, v2, done, busy, fi, fj},
              32'd0);
        start = 0;
        sb.delete();
        #2 rst_n = 1;
        tick();
        check("rst_start_ignored", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check("rst_no_done", n_done, 32'd0);

        // K=4 stream into an accumulator-style collector
        b4 = 4'h5;
        one4 = 4'd1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            exp4[k] = b4 ^ (one4 << i);
            k++;
        end
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++) begin
                exp4[k] = b4 ^ (one4 << i) ^ (one4 << j);
                k++;
            end
        base4 = b4;
        start4 = 1;
        tick();
        start4 = 0;
        k = 0;
        while (n_done4 == 0 && k < 100) begin
            tick();
            k++;
        end
        check("k4_done", n_done4, 32'd1);
        check("k4_count", n4, 32'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("k4_cand%0d", i), got4[i], exp4[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
